// File: rtl/bp_be_pkg.sv
// Shared types for the backend memory-issue path.
//   bp_be_mem_issue_pkt_s        : one dispatched memory request
//   bp_be_mem_issue_pkt_width_gp : packed width of that request
//   bp_be_misaligned()           : size/low-address alignment rule
package bp_be_pkg;

    localparam int vaddr_width_gp = 39;
    localparam int dpath_width_gp = 64;

    typedef struct packed {
        logic [vaddr_width_gp-1:0] pc;
        logic [4:0]                rd_addr;
        logic [6:0]                opcode;
        logic [1:0]                size;
        logic                      is_load;
        logic                      is_store;
        logic [dpath_width_gp-1:0] rs1;
        logic [dpath_width_gp-1:0] rs2;
        logic [dpath_width_gp-1:0] imm;
    } bp_be_mem_issue_pkt_s;

    localparam int bp_be_mem_issue_pkt_width_gp = $bits(bp_be_mem_issue_pkt_s);

    // size encodes 1/2/4/8 bytes; the access is misaligned when any
    // address bit below the access size is set.
    function automatic logic bp_be_misaligned(input logic [1:0] size,
                                              input logic [2:0] eaddr_low);
        logic mis;
        mis = 1'b0;
        case (size)
            2'd1:    mis = eaddr_low[0];
            2'd2:    mis = |eaddr_low[1:0];
            2'd3:    mis = |eaddr_low[2:0];
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/bp_be_mem_align_check.sv
// Combinational alignment checker used at enqueue.
//   size_i       : access size code (0=byte .. 3=double)
//   eaddr_low_i  : low three bits of the effective address
//   misaligned_o : access does not sit on its natural boundary
module bp_be_mem_align_check
    import bp_be_pkg::*;
(
    input  logic [1:0] size_i,
    input  logic [2:0] eaddr_low_i,
    output logic       misaligned_o
);

    assign misaligned_o = bp_be_misaligned(size_i, eaddr_low_i);

endmodule

// File: rtl/bp_be_mem_issue_buffer.sv
// Small FIFO between dispatch and the memory pipe. The effective address
// and misalignment flag are computed on the way in, so the head entry
// presents them without an adder on the output path.
//   clk_i, reset_n_i  : clock, asynchronous active-low reset
//   flush_i           : drop everything buffered and the incoming request
//   v_i/ready_o/pkt_i : dispatch side handshake and request
//   v_o/ready_i/pkt_o : memory pipe side handshake and head request
//   eaddr_o           : head effective address (rs1+imm, truncated)
//   load_/store_misaligned_o : head misalignment, qualified by type
//   count_o           : occupancy
module bp_be_mem_issue_buffer
    import bp_be_pkg::*;
#(
    parameter int els_p         = 2,
    parameter int vaddr_width_p = vaddr_width_gp,
    parameter int dpath_width_p = dpath_width_gp
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    input  logic                         flush_i,
    input  logic                         v_i,
    output logic                         ready_o,
    input  bp_be_mem_issue_pkt_s         pkt_i,
    output logic                         v_o,
    input  logic                         ready_i,
    output bp_be_mem_issue_pkt_s         pkt_o,
    output logic [vaddr_width_p-1:0]     eaddr_o,
    output logic                         load_misaligned_o,
    output logic                         store_misaligned_o,
    output logic [$clog2(els_p+1)-1:0]   count_o
);

    localparam int ptr_width_lp = $clog2(els_p);
    localparam int cnt_width_lp = $clog2(els_p+1);

    logic [ptr_width_lp-1:0] rptr_reg, wptr_reg;
    logic [cnt_width_lp-1:0] count_reg;

    // Storage is deliberately unreset; validity lives in count_reg.
    bp_be_mem_issue_pkt_s    pkt_mem   [els_p];
    logic [vaddr_width_p-1:0] eaddr_mem [els_p];
    logic                    mis_mem   [els_p];

    logic [dpath_width_p-1:0] eaddr_full;
    logic                     eaddr_unused_hi;
    logic                     mis_in;
    logic                     enq, deq;

    assign eaddr_full      = dpath_width_p'(pkt_i.rs1) + dpath_width_p'(pkt_i.imm);
    assign eaddr_unused_hi = ^eaddr_full[dpath_width_p-1:vaddr_width_p];

    bp_be_mem_align_check align_check (
        .size_i       (pkt_i.size),
        .eaddr_low_i  (eaddr_full[2:0]),
        .misaligned_o (mis_in)
    );

    assign v_o     = (count_reg != '0);
    assign deq     = v_o & ready_i;
    // Full buffer can still accept when the head leaves in the same cycle.
    assign ready_o = (count_reg < cnt_width_lp'(els_p)) | deq;
    assign enq     = v_i & ready_o & ~flush_i;

    function automatic logic [ptr_width_lp-1:0] ptr_inc(input logic [ptr_width_lp-1:0] p);
        return (p == ptr_width_lp'(els_p-1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rptr_reg  <= '0;
            wptr_reg  <= '0;
            count_reg <= '0;
        end else if (flush_i) begin
            rptr_reg  <= '0;
            wptr_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (enq) wptr_reg <= ptr_inc(wptr_reg);
            if (deq) rptr_reg <= ptr_inc(rptr_reg);
            case ({enq, deq})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq) begin
            pkt_mem[wptr_reg]   <= pkt_i;
            eaddr_mem[wptr_reg] <= eaddr_full[vaddr_width_p-1:0];
            mis_mem[wptr_reg]   <= mis_in;
        end
    end

    // Gate by v_o so never-written entries cannot leak X after reset.
    assign pkt_o              = v_o ? pkt_mem[rptr_reg]   : '0;
    assign eaddr_o            = v_o ? eaddr_mem[rptr_reg] : '0;
    assign load_misaligned_o  = v_o & pkt_mem[rptr_reg].is_load  & mis_mem[rptr_reg];
    assign store_misaligned_o = v_o & pkt_mem[rptr_reg].is_store & mis_mem[rptr_reg];
    assign count_o            = count_reg;

endmodule

// File: tb/tb_bp_be_mem_issue_buffer.sv
module tb_bp_be_mem_issue_buffer;
    import bp_be_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Instance a: depth 2, directed tests
    logic                 a_flush = 0, a_v_i = 0, a_ready_i = 0;
    bp_be_mem_issue_pkt_s a_pkt_i = '0;
    logic                 a_ready_o, a_v_o, a_lmis, a_smis;
    bp_be_mem_issue_pkt_s a_pkt_o;
    logic [38:0]          a_eaddr;
    logic [1:0]           a_count;

    bp_be_mem_issue_buffer #(.els_p(2)) dut_a (
        .clk_i(clk), .reset_n_i(reset_n), .flush_i(a_flush),
        .v_i(a_v_i), .ready_o(a_ready_o), .pkt_i(a_pkt_i),
        .v_o(a_v_o), .ready_i(a_ready_i), .pkt_o(a_pkt_o),
        .eaddr_o(a_eaddr), .load_misaligned_o(a_lmis),
        .store_misaligned_o(a_smis), .count_o(a_count)
    );

    // Instance b: depth 3, random ordering/wrap test
    logic                 b_flush = 0, b_v_i = 0, b_ready_i = 0;
    bp_be_mem_issue_pkt_s b_pkt_i = '0;
    logic                 b_ready_o, b_v_o, b_lmis, b_smis;
    bp_be_mem_issue_pkt_s b_pkt_o;
    logic [38:0]          b_eaddr;
    logic [1:0]           b_count;

    bp_be_mem_issue_buffer #(.els_p(3)) dut_b (
        .clk_i(clk), .reset_n_i(reset_n), .flush_i(b_flush),
        .v_i(b_v_i), .ready_o(b_ready_o), .pkt_i(b_pkt_i),
        .v_o(b_v_o), .ready_i(b_ready_i), .pkt_o(b_pkt_o),
        .eaddr_o(b_eaddr), .load_misaligned_o(b_lmis),
        .store_misaligned_o(b_smis), .count_o(b_count)
    );

    function automatic bp_be_mem_issue_pkt_s mk(input logic [38:0] pc, input logic [1:0] size,
                                                 input logic ld, input logic st,
                                                 input logic [63:0] rs1, input logic [63:0] imm);
        bp_be_mem_issue_pkt_s p;
        p          = '0;
        p.pc       = pc;
        p.rd_addr  = pc[4:0];
        p.opcode   = 7'h03;
        p.size     = size;
        p.is_load  = ld;
        p.is_store = st;
        p.rs1      = rs1;
        p.rs2      = 64'h5a5a;
        p.imm      = imm;
        return p;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to 2 time units past the next rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    typedef struct { logic [38:0] pc; logic [38:0] ea; } exp_t;
    exp_t q[$];

    initial begin
        // ---- reset state ----
        #2;
        chk("rst_count", 64'(a_count), 0);
        chk("rst_v_o", 64'(a_v_o), 0);
        chk("rst_ready", 64'(a_ready_o), 1);
        chk("rst_mis", 64'({a_lmis, a_smis}), 0);
        #11 reset_n = 1'b1;            // release mid-cycle
        tick();

        // ---- basic latency; enqueue into empty with ready_i=1 ----
        a_ready_i = 1; a_v_i = 1;
        a_pkt_i = mk(39'h100, 2'd3, 1, 0, 64'h1000, 64'h8);
        #1 chk("lat_no_bypass", 64'(a_v_o), 0);
        tick();
        a_v_i = 0;
        #1;
        chk("lat_v_o", 64'(a_v_o), 1);
        chk("lat_count", 64'(a_count), 1);
        chk("lat_eaddr", 64'(a_eaddr), 64'h1008);
        chk("lat_lmis", 64'(a_lmis), 0);
        chk("lat_pc", 64'(a_pkt_o.pc), 64'h100);
        tick();
        #1 chk("lat_drained", 64'(a_v_o), 0);

        // ---- misalignment ----
        a_ready_i = 0; a_v_i = 1;
        a_pkt_i = mk(39'h101, 2'd2, 0, 1, 64'h1001, 64'h0);
        tick();
        a_ready_i = 1;
        a_pkt_i = mk(39'h102, 2'd0, 0, 1, 64'h1001, 64'h0);
        #1;
        chk("mis_smis", 64'(a_smis), 1);
        chk("mis_lmis", 64'(a_lmis), 0);
        tick();
        a_v_i = 0;
        #1;
        chk("mis_b_pc", 64'(a_pkt_o.pc), 64'h102);
        chk("mis_b_flags", 64'({a_lmis, a_smis}), 0);
        chk("mis_b_count", 64'(a_count), 1);
        tick();

        // ---- full and backpressure ----
        a_ready_i = 0; a_v_i = 1;
        a_pkt_i = mk(39'h0a, 2'd0, 1, 0, 64'h20, 64'h1);
        tick();
        a_pkt_i = mk(39'h0b, 2'd0, 1, 0, 64'h30, 64'h2);
        tick();
        a_v_i = 0;
        #1;
        chk("full_count", 64'(a_count), 2);
        chk("full_ready", 64'(a_ready_o), 0);
        chk("full_hold_pc", 64'(a_pkt_o.pc), 64'h0a);
        chk("full_hold_ea", 64'(a_eaddr), 64'h21);
        a_ready_i = 1; a_v_i = 1;
        a_pkt_i = mk(39'h0c, 2'd0, 1, 0, 64'h40, 64'h3);
        #1 chk("full_pass_ready", 64'(a_ready_o), 1);
        tick();
        a_v_i = 0; a_ready_i = 0;
        #1;
        chk("full_pass_count", 64'(a_count), 2);
        chk("full_pass_head", 64'(a_pkt_o.pc), 64'h0b);

        // ---- flush with incoming request ----
        a_flush = 1; a_v_i = 1;
        a_pkt_i = mk(39'h0d, 2'd0, 1, 0, 64'h50, 64'h0);
        #1 chk("flush_v_o_same", 64'(a_v_o), 1);
        tick();
        a_flush = 0; a_v_i = 0; a_ready_i = 1;
        #1;
        chk("flush_count", 64'(a_count), 0);
        chk("flush_v_o", 64'(a_v_o), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("flush_dropped", 64'(a_v_o), 0);
        end

        // ---- asynchronous reset mid-operation ----
        a_ready_i = 0; a_v_i = 1;
        a_pkt_i = mk(39'h0e, 2'd0, 1, 0, 64'h60, 64'h0);
        tick();
        a_v_i = 0;
        #1 chk("ar_v_before", 64'(a_v_o), 1);
        reset_n = 1'b0;                // mid-cycle, no edge
        #1;
        chk("ar_v_o", 64'(a_v_o), 0);
        chk("ar_count", 64'(a_count), 0);
        chk("ar_ready", 64'(a_ready_o), 1);
        #1 reset_n = 1'b1;
        tick();
        a_v_i = 1;
        a_pkt_i = mk(39'h0f, 2'd1, 1, 0, 64'h71, 64'h0);
        tick();
        a_v_i = 0;
        #1;
        chk("ar_first_pc", 64'(a_pkt_o.pc), 64'h0f);
        chk("ar_first_count", 64'(a_count), 1);
        chk("ar_first_lmis", 64'(a_lmis), 1);

        // ---- random ordering and wrap on depth 3 ----
        begin
            int unsigned next_pc = 1;
            logic acc, dq;
            exp_t e;
            for (int cyc = 0; cyc < 1000; cyc++) begin
                b_v_i     = ($urandom_range(0, 99) < 60);
                b_ready_i = ($urandom_range(0, 99) < 55);
                b_pkt_i   = mk(39'(next_pc), 2'd0, 1, 0, 64'($urandom), 64'($urandom_range(0, 255)));
                #1;
                chk("rnd_count", 64'(b_count), 64'(q.size()));
                dq  = b_v_o & b_ready_i;
                acc = b_v_i & b_ready_o;
                chk("rnd_ready", 64'(b_ready_o), 64'((q.size() < 3) || dq));
                if (dq) begin
                    if (q.size() == 0) begin
                        chk("rnd_underflow", 64'(b_v_o), 0);
                    end else begin
                        e = q.pop_front();
                        chk("rnd_order_pc", 64'(b_pkt_o.pc), 64'(e.pc));
                        chk("rnd_eaddr", 64'(b_eaddr), 64'(e.ea));
                    end
                end
                if (acc) begin
                    e.pc = 39'(next_pc);
                    e.ea = 39'(b_pkt_i.rs1 + b_pkt_i.imm);
                    q.push_back(e);
                    next_pc++;
                end
                tick();
            end
            b_v_i = 0; b_ready_i = 1;
            for (int i = 0; i < 6; i++) begin
                #1;
                if (b_v_o) begin
                    if (q.size() == 0) begin
                        chk("rnd_dup", 64'(b_v_o), 0);
                    end else begin
                        e = q.pop_front();
                        chk("rnd_drain_pc", 64'(b_pkt_o.pc), 64'(e.pc));
                    end
                end
                tick();
            end
            chk("rnd_loss", 64'(q.size()), 0);
            chk("rnd_empty", 64'(b_count), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
